bus_cycle_terminator: RTL and testbench
=======================================

Name: bus_cycle_terminator

Overview:
- Sits directly downstream of the system controller's chip-select decode on the 68030 board.
- Consumes per-device chip selects, address strobe and the DUART's DTACK.
- Produces the CPU cycle-termination signals: DSACK0_n/DSACK1_n with per-device wait states, and BERR_n on timeout for unmapped or hung cycles.
- Replaces the constant "DSACK0_n = 0, BERR_n = 1" termination with a clocked state machine.

Parameters:
- ROM_WAIT, 2, wait states inserted before DSACK0_n for ROM cycles (0..15)
- SRAM_WAIT, 0, wait states for SRAM cycles (0..15)
- BERR_TIMEOUT, 64, clocks from cycle start until BERR_n is asserted (≥ 8)
- SYNC_STAGES, 2, flip-flop stages on DTACK_DUART_n (≥ 2)

Ports:
- CLK  input  1  CPU clock; all state changes on rising edge
- RST  input  1  async active-high reset
- AS_n  input  1  CPU address strobe, synchronous to CLK
- CS_ROM_n  input  1  ROM chip select
- CS_SRAM_n  input  1  SRAM chip select
- CS_DUART_n  input  1  DUART chip select
- IACK_DUART_n  input  1  DUART interrupt-acknowledge select
- DTACK_DUART_n  input  1  DUART transfer ack, asynchronous to CLK
- DSACK0_n  output  1  8-bit port termination (registered)
- DSACK1_n  output  1  constant 1; all ports are 8-bit
- BERR_n  output  1  bus error (registered)
- CYCLE_BUSY  output  1  high whenever state ≠ IDLE

Behaviour:
- Reset (RST=1, asynchronous):
  - State = IDLE.
  - DSACK0_n = 1, BERR_n = 1, CYCLE_BUSY = 0.
  - Wait counter and timeout counter = 0.
  - Synchronizer flops = 1.
- DTACK_DUART_n passes through a SYNC_STAGES flop chain reset to 1. Output is dtack_s.
- Counters:
  - Wait counter is 4 bits.
  - Timeout counter is $clog2(BERR_TIMEOUT+1) bits and saturates; it never wraps.
- States: IDLE, DECODE, WAIT, DTACK, ACK, BERR.
- IDLE:
  - On an edge with AS_n=0, go to DECODE and clear tmo to 0.
  - Otherwise remain in IDLE.
- DECODE / WAIT / DTACK common rules, in priority order:
  - (a) AS_n=1: abort, go to IDLE, outputs stay negated.
  - (b) A termination condition is met: go to ACK. Termination takes priority over timeout on the same edge.
  - (c) tmo == BERR_TIMEOUT-1: go to BERR.
  - (d) Otherwise tmo += 1.
- DECODE: the first chip select found low, in priority ROM > SRAM > DUART > IACK_DUART, selects the next state.
  - ROM: go to WAIT with cnt = ROM_WAIT.
  - SRAM: go to WAIT with cnt = SRAM_WAIT.
  - DUART or IACK_DUART: go to DTACK.
  - No select low: stay in DECODE. This waits for a late DS_n on writes; an unmapped cycle ends in BERR.
- WAIT:
  - cnt == 0 is the termination condition: go to ACK.
  - Else cnt -= 1.
- DTACK: dtack_s == 0 is the termination condition.
- ACK:
  - DSACK0_n = 0, registered on entry.
  - Held until an edge samples AS_n=1. That edge goes to IDLE and sets DSACK0_n = 1.
- BERR:
  - BERR_n = 0 with DSACK0_n = 1.
  - Held until an edge samples AS_n=1. That edge goes to IDLE and sets BERR_n = 1.
- DSACK0_n and BERR_n are never low simultaneously.
- Latency:
  - Call E0 the edge that samples AS_n=0 in IDLE.
  - With a chip select already low at E0+1, DSACK0_n falls after edge E0+2+W, where W is the device's wait count.
  - DUART: DSACK0_n falls SYNC_STAGES+1 edges after the first edge that samples DTACK_DUART_n=0.
  - BERR_n falls after edge E0+BERR_TIMEOUT.
- Back-to-back cycles: AS_n high for a single sampled edge is enough to return to IDLE. A new cycle may start on the next edge.
- Reset asserted mid-cycle: all outputs negate immediately (asynchronously).
- DTACK_DUART_n still low from a previous cycle is not specially filtered. The DUART releases it on CS negation; the synchronizer delay is covered by the IDLE/DECODE cycles.

Test Plan:
- Reset: RST=1 mid-cycle with DSACK0_n=0 → DSACK0_n=1, BERR_n=1, CYCLE_BUSY=0 before the next edge.
- ROM read, ROM_WAIT=2: AS_n low at edge 0, CS_ROM_n low from edge 1 → DSACK0_n low after edge 4. AS_n high at edge 7 → DSACK0_n high after edge 7.
- SRAM, SRAM_WAIT=0, back-to-back: two cycles separated by one AS_n-high edge → DSACK0_n low after edge 2 of each cycle. Both cycles terminate; no BERR.
- DUART: CS_DUART_n low, DTACK_DUART_n falls 10 clocks later → DSACK0_n low exactly 3 edges after DTACK is first sampled low (SYNC_STAGES=2). No BERR if within 64 clocks.
- Unmapped: AS_n low with no chip select, BERR_TIMEOUT=64 → BERR_n low after edge 64, DSACK0_n stays 1. AS_n high → BERR_n high on that edge.
- Timeout race and abort:
  - DTACK synchronized on the same edge tmo reaches 63 → ACK wins, BERR_n stays 1.
  - AS_n high during WAIT → IDLE, no DSACK0_n pulse.

Source files
------------

// File: rtl/bus_cycle_terminator.sv
// 68030 bus-cycle terminator: DSACK0_n with per-device wait states, DUART DTACK
// handshake through a synchronizer, and BERR_n on a saturating cycle timeout.
module bus_cycle_terminator #(
  parameter int ROM_WAIT     = 2,
  parameter int SRAM_WAIT    = 0,
  parameter int BERR_TIMEOUT = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic AS_n,
  input  logic CS_ROM_n,
  input  logic CS_SRAM_n,
  input  logic CS_DUART_n,
  input  logic IACK_DUART_n,
  input  logic DTACK_DUART_n,
  output logic DSACK0_n,
  output logic DSACK1_n,
  output logic BERR_n,
  output logic CYCLE_BUSY
);

  localparam int TMO_W = $clog2(BERR_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BERR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT, S_DTACK, S_ACK, S_BERR
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic [TMO_W-1:0]       r_tmo, w_tmo_nxt, w_tmo_inc;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dtack_s;
  logic                   r_dsack0_n, r_berr_n;
  logic                   w_term;

  // The chain output is retimed once more, so DSACK0_n follows the first low
  // sample of DTACK_DUART_n by SYNC_STAGES+1 edges.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync    <= '1;
      r_dtack_s <= 1'b1;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], DTACK_DUART_n};
      r_dtack_s <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_tmo_inc = (r_tmo == '1) ? r_tmo : r_tmo + TMO_W'(1);
  assign w_term    = ((r_state == S_WAIT) && (r_cnt == 4'd0)) ||
                     ((r_state == S_DTACK) && !r_dtack_s);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    case (r_state)
      S_IDLE: begin
        if (!AS_n) begin
          w_state_nxt = S_DECODE;
          w_tmo_nxt   = '0;
        end
      end
      S_DECODE, S_WAIT, S_DTACK: begin
        if (AS_n) begin
          w_state_nxt = S_IDLE;
        end else if (w_term) begin
          w_state_nxt = S_ACK;
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt = S_BERR;
        end else begin
          w_tmo_nxt = w_tmo_inc;
          if (r_state == S_DECODE) begin
            if (!CS_ROM_n) begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = 4'(ROM_WAIT);
            end else if (!CS_SRAM_n) begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = 4'(SRAM_WAIT);
            end else if (!CS_DUART_n || !IACK_DUART_n) begin
              w_state_nxt = S_DTACK;
            end
          end else if (r_state == S_WAIT) begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      S_ACK, S_BERR: begin
        if (AS_n) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_tmo      <= '0;
      r_dsack0_n <= 1'b1;
      r_berr_n   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmo      <= w_tmo_nxt;
      r_dsack0_n <= (w_state_nxt != S_ACK);
      r_berr_n   <= (w_state_nxt != S_BERR);
    end
  end

  assign DSACK0_n   = r_dsack0_n;
  assign DSACK1_n   = 1'b1;
  assign BERR_n     = r_berr_n;
  assign CYCLE_BUSY = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_cycle_terminator.sv
// Scoreboard bench for bus_cycle_terminator: stimulus queues the expected output
// edges, a negedge monitor pops and compares each DSACK0_n/BERR_n transition.
module tb_bus_cycle_terminator;

  localparam int EV_DS_FALL = 0;
  localparam int EV_DS_RISE = 1;
  localparam int EV_BE_FALL = 2;
  localparam int EV_BE_RISE = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic AS_n = 1'b1, CS_ROM_n = 1'b1, CS_SRAM_n = 1'b1, CS_DUART_n = 1'b1;
  logic IACK_DUART_n = 1'b1, DTACK_DUART_n = 1'b1;
  logic DSACK0_n, DSACK1_n, BERR_n, CYCLE_BUSY;

  bus_cycle_terminator #(
    .ROM_WAIT(2), .SRAM_WAIT(0), .BERR_TIMEOUT(64), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .RST(RST), .AS_n(AS_n), .CS_ROM_n(CS_ROM_n), .CS_SRAM_n(CS_SRAM_n),
    .CS_DUART_n(CS_DUART_n), .IACK_DUART_n(IACK_DUART_n), .DTACK_DUART_n(DTACK_DUART_n),
    .DSACK0_n(DSACK0_n), .DSACK1_n(DSACK1_n), .BERR_n(BERR_n), .CYCLE_BUSY(CYCLE_BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t q[$];
  int  edge_cnt = 0;
  int  checks = 0;
  int  errors = 0;
  logic prev_ds = 1'b1, prev_be = 1'b1;

  always @(posedge CLK) edge_cnt++;

  task automatic expect_ev(input int kind, input int at);
    q.push_back('{kind, at});
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic sb_pop(input int kind, input logic other);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d after edge %0d, expected none", kind, edge_cnt);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.at != edge_cnt) begin
        errors++;
        $display("FAIL event_order: got kind %0d after edge %0d, expected kind %0d after edge %0d",
                 kind, edge_cnt, e.kind, e.at);
      end else if ((kind == EV_DS_FALL || kind == EV_BE_FALL) && other !== 1'b1) begin
        errors++;
        $display("FAIL exclusive: other termination is %b, expected 1 (edge %0d)", other, edge_cnt);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (prev_ds === 1'b1 && DSACK0_n === 1'b0) sb_pop(EV_DS_FALL, BERR_n);
      if (prev_ds === 1'b0 && DSACK0_n === 1'b1) sb_pop(EV_DS_RISE, BERR_n);
      if (prev_be === 1'b1 && BERR_n === 1'b0) sb_pop(EV_BE_FALL, DSACK0_n);
      if (prev_be === 1'b0 && BERR_n === 1'b1) sb_pop(EV_BE_RISE, DSACK0_n);
    end
    prev_ds = DSACK0_n;
    prev_be = BERR_n;
  end

  task automatic wait_until(input int e);
    while (edge_cnt < e) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, t;
    repeat (3) @(negedge CLK);
    check1("reset_dsack0", DSACK0_n, 1'b1);
    check1("reset_berr", BERR_n, 1'b1);
    check1("reset_busy", CYCLE_BUSY, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    check1("dsack1_const", DSACK1_n, 1'b1);

    // ROM read with two wait states
    AS_n = 1'b0; e0 = edge_cnt + 1;
    expect_ev(EV_DS_FALL, e0 + 4);
    expect_ev(EV_DS_RISE, e0 + 7);
    wait_until(e0);
    CS_ROM_n = 1'b0;
    check1("rom_busy", CYCLE_BUSY, 1'b1);
    wait_until(e0 + 6);
    AS_n = 1'b1; CS_ROM_n = 1'b1;
    wait_until(e0 + 9);

    // SRAM back-to-back, one AS_n-high edge between cycles
    AS_n = 1'b0; CS_SRAM_n = 1'b0; e0 = edge_cnt + 1;
    expect_ev(EV_DS_FALL, e0 + 2);
    expect_ev(EV_DS_RISE, e0 + 4);
    wait_until(e0 + 3);
    AS_n = 1'b1;
    wait_until(e0 + 4);
    AS_n = 1'b0; e1 = e0 + 5;
    expect_ev(EV_DS_FALL, e1 + 2);
    expect_ev(EV_DS_RISE, e1 + 4);
    wait_until(e1 + 3);
    AS_n = 1'b1; CS_SRAM_n = 1'b1;
    wait_until(e1 + 6);

    // DUART: DTACK asserted ten clocks into the cycle
    AS_n = 1'b0; CS_DUART_n = 1'b0; e0 = edge_cnt + 1;
    wait_until(e0 + 9);
    DTACK_DUART_n = 1'b0; t = e0 + 10;
    expect_ev(EV_DS_FALL, t + 3);
    expect_ev(EV_DS_RISE, t + 5);
    wait_until(t + 4);
    AS_n = 1'b1; CS_DUART_n = 1'b1; DTACK_DUART_n = 1'b1;
    wait_until(t + 10);

    // Unmapped cycle times out into BERR
    AS_n = 1'b0; e0 = edge_cnt + 1;
    expect_ev(EV_BE_FALL, e0 + 64);
    expect_ev(EV_BE_RISE, e0 + 70);
    wait_until(e0 + 63);
    check1("berr_not_early", BERR_n, 1'b1);
    wait_until(e0 + 64);
    check1("berr_dsack_high", DSACK0_n, 1'b1);
    check1("berr_low", BERR_n, 1'b0);
    wait_until(e0 + 69);
    AS_n = 1'b1;
    wait_until(e0 + 72);

    // DTACK synchronized on the edge tmo reaches 63: ACK beats BERR
    AS_n = 1'b0; IACK_DUART_n = 1'b0; e0 = edge_cnt + 1;
    wait_until(e0 + 60);
    DTACK_DUART_n = 1'b0;
    expect_ev(EV_DS_FALL, e0 + 64);
    expect_ev(EV_DS_RISE, e0 + 66);
    wait_until(e0 + 65);
    AS_n = 1'b1; IACK_DUART_n = 1'b1; DTACK_DUART_n = 1'b1;
    wait_until(e0 + 70);

    // AS_n negated during WAIT: abort with no DSACK0_n pulse
    AS_n = 1'b0; CS_ROM_n = 1'b0; e0 = edge_cnt + 1;
    wait_until(e0 + 2);
    check1("abort_busy_before", CYCLE_BUSY, 1'b1);
    AS_n = 1'b1; CS_ROM_n = 1'b1;
    wait_until(e0 + 3);
    check1("abort_idle", CYCLE_BUSY, 1'b0);
    check1("abort_dsack", DSACK0_n, 1'b1);
    wait_until(e0 + 8);

    // Asynchronous reset while DSACK0_n is asserted
    AS_n = 1'b0; CS_SRAM_n = 1'b0; e0 = edge_cnt + 1;
    expect_ev(EV_DS_FALL, e0 + 2);
    wait_until(e0 + 3);
    check1("pre_reset_dsack", DSACK0_n, 1'b0);
    #2 RST = 1'b1;
    #1;
    check1("async_rst_dsack", DSACK0_n, 1'b1);
    check1("async_rst_berr", BERR_n, 1'b1);
    check1("async_rst_busy", CYCLE_BUSY, 1'b0);
    repeat (2) @(negedge CLK);
    AS_n = 1'b1; CS_SRAM_n = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
